// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_scheduler
// Purpose  : Round-robin scheduler that shares one combinational ALU among
//            NUM_REQ requesters. One operation is accepted at a time, its
//            operands are registered onto the ALU inputs, and the ALU result
//            and flags are captured one cycle later. The result is returned
//            with the requester ID over a valid/ready response handshake.
// Ports    :
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid / req_ready         per-requester handshake (ready is one-hot)
//   req_opcode/req_a/req_b/       packed per-requester payload, requester i
//   req_shift                     uses slice i
//   alu_opcode/alu_input1/        registered ALU drive
//   alu_input2/alu_shift
//   alu_result/alu_carry/         ALU outputs (combinational from alu_*)
//   alu_zero/alu_overflow
//   rsp_valid / rsp_ready         response handshake
//   rsp_id/rsp_result/rsp_carry/  response payload, stable while rsp_valid
//   rsp_zero/rsp_overflow/rsp_err
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128,
  parameter int OPW     = 4,
  parameter int SHW     = 5,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // requester side
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OPW-1:0]   req_opcode,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SHW-1:0]   req_shift,
  // ALU drive
  output logic [OPW-1:0]           alu_opcode,
  output logic [WIDTH-1:0]         alu_input1,
  output logic [WIDTH-1:0]         alu_input2,
  output logic [SHW-1:0]           alu_shift,
  // ALU return
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  input  logic                     alu_zero,
  input  logic                     alu_overflow,
  // response side
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     rsp_overflow,
  output logic                     rsp_err
);

  // --------------------------------------------------------------------------
  // Constants and state
  // --------------------------------------------------------------------------
  // Number of legal ALU opcodes; larger opcode values raise rsp_err.
  localparam logic [31:0]    c_num_legal_ops = 32'd8;
  // Reset value of the last grant: makes requester 0 the first in line.
  localparam logic [IDW-1:0] c_last_init     = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_last_grant;

  logic [OPW-1:0]   r_alu_opcode;
  logic [WIDTH-1:0] r_alu_input1;
  logic [WIDTH-1:0] r_alu_input2;
  logic [SHW-1:0]   r_alu_shift;

  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_carry;
  logic             r_rsp_zero;
  logic             r_rsp_overflow;
  logic             r_rsp_err;

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------
  // Each requester's priority is its distance from the slot after the last
  // grant (0 = highest). The valid requester with the smallest distance wins,
  // so the most recently granted requester always ranks last.
  logic           w_grant_found;
  logic [IDW-1:0] w_grant_idx;
  int             w_best;
  int             w_dist;

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_best        = NUM_REQ;
    w_dist        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best        = w_dist;
        w_grant_idx   = IDW'(i);
        w_grant_found = 1'b1;
      end
    end
  end

  // An operation is accepted only from IDLE; requests seen in EXEC or RESP
  // simply wait at the requester.
  logic w_accept;
  assign w_accept = (r_state == ST_IDLE) && w_grant_found;

  // Ready is forced low while reset is held so no handshake can appear to
  // complete while the scheduler is being cleared.
  logic [NUM_REQ-1:0] w_req_ready;

  always_comb begin
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && w_accept && (w_grant_idx == IDW'(i))) begin
        w_req_ready[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Payload selection for the winning requester
  // --------------------------------------------------------------------------
  logic [OPW-1:0]   w_sel_opcode;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [SHW-1:0]   w_sel_shift;

  always_comb begin
    w_sel_opcode = '0;
    w_sel_a      = '0;
    w_sel_b      = '0;
    w_sel_shift  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_sel_opcode = req_opcode[i*OPW +: OPW];
        w_sel_a      = req_a[i*WIDTH +: WIDTH];
        w_sel_b      = req_b[i*WIDTH +: WIDTH];
        w_sel_shift  = req_shift[i*SHW +: SHW];
      end
    end
  end

  // The ALU output is meaningless for unimplemented opcodes; those produce a
  // zero result with all flags clear and the error bit set instead.
  logic w_illegal_op;
  assign w_illegal_op = (32'(r_alu_opcode) >= c_num_legal_ops);

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= c_last_init;
      r_alu_opcode   <= '0;
      r_alu_input1   <= '0;
      r_alu_input2   <= '0;
      r_alu_shift    <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_result   <= '0;
      r_rsp_carry    <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // ALU drive registers change only here, so they hold the last
          // operation for as long as the scheduler is otherwise quiet.
          if (w_accept) begin
            r_alu_opcode <= w_sel_opcode;
            r_alu_input1 <= w_sel_a;
            r_alu_input2 <= w_sel_b;
            r_alu_shift  <= w_sel_shift;
            r_rsp_id     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_state      <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // The ALU has had a full cycle to settle on the registered inputs.
          if (w_illegal_op) begin
            r_rsp_result   <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_err      <= 1'b1;
          end else begin
            r_rsp_result   <= alu_result;
            r_rsp_carry    <= alu_carry;
            r_rsp_zero     <= alu_zero;
            r_rsp_overflow <= alu_overflow;
            r_rsp_err      <= 1'b0;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign req_ready    = w_req_ready;
  assign alu_opcode   = r_alu_opcode;
  assign alu_input1   = r_alu_input1;
  assign alu_input2   = r_alu_input2;
  assign alu_shift    = r_alu_shift;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_err      = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_scheduler
// Purpose  : Self-checking bench for alu_rr_scheduler. Supplies a
//            combinational 128-bit ALU, directed scenarios and randomized
//            traffic, and compares the scheduler against a transaction-level
//            model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

  localparam int N   = 4;
  localparam int W   = 128;
  localparam int OPW = 4;
  localparam int SHW = 5;
  localparam int IDW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*OPW-1:0] req_opcode;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N*SHW-1:0] req_shift;
  logic [OPW-1:0]   alu_opcode;
  logic [W-1:0]     alu_input1;
  logic [W-1:0]     alu_input2;
  logic [SHW-1:0]   alu_shift;
  logic [W-1:0]     alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .OPW(OPW), .SHW(SHW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS B, 5 XOR, 6 SHL a, 7 NOR.
  // Unimplemented opcodes return deliberate garbage with flags set.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } alu_o_t;

  function automatic alu_o_t alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [SHW-1:0] sh);
    alu_o_t     o;
    logic [W:0] t;
    o = '0;
    t = '0;
    case (op)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; o.res = t[W-1:0]; o.c = t[W];
                  o.v = (a[W-1] == b[W-1]) && (o.res[W-1] != a[W-1]); end
      4'd1: begin t = {1'b0, a} - {1'b0, b}; o.res = t[W-1:0]; o.c = t[W];
                  o.v = (a[W-1] != b[W-1]) && (o.res[W-1] != a[W-1]); end
      4'd2: o.res = a & b;
      4'd3: o.res = a | b;
      4'd4: o.res = b;
      4'd5: o.res = a ^ b;
      4'd6: o.res = a << sh;
      4'd7: o.res = ~(a | b);
      default: begin o.res = ~a; o.c = 1'b1; o.v = 1'b1; end
    endcase
    o.z = (op < 4'd8) ? (o.res == '0) : 1'b1;
    return o;
  endfunction

  alu_o_t w_alu;
  assign w_alu        = alu_f(alu_opcode, alu_input1, alu_input2, alu_shift);
  assign alu_result   = w_alu.res;
  assign alu_carry    = w_alu.c;
  assign alu_zero     = w_alu.z;
  assign alu_overflow = w_alu.v;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // First valid requester scanning forward from the one after `last`.
  function automatic int winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_payload(input int i, input logic [OPW-1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [SHW-1:0] sh);
    req_opcode[i*OPW +: OPW] = op;
    req_a[i*W +: W]          = a;
    req_b[i*W +: W]          = b;
    req_shift[i*SHW +: SHW]  = sh;
  endtask

  task automatic rand_payload(input int i);
    set_payload(i, OPW'($urandom_range(0, 9)), rnd128(), rnd128(), SHW'($urandom_range(0, 31)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level reference model, checked on every falling edge.
  // --------------------------------------------------------------------------
  logic           m_busy;
  int             m_age;
  int             m_last;
  int             m_id;
  logic [OPW-1:0] m_op;
  logic [W-1:0]   m_a;
  logic [W-1:0]   m_b;
  logic [SHW-1:0] m_sh;
  alu_o_t         m_exp;
  logic           m_err;

  initial begin
    int w;
    m_busy = 1'b0; m_age = 0; m_last = N - 1; m_id = 0;
    m_op = '0; m_a = '0; m_b = '0; m_sh = '0; m_exp = '0; m_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_last = N - 1;
        m_op = '0; m_a = '0; m_b = '0; m_sh = '0;
      end else begin
        chk("m_alu_opcode", W'(alu_opcode), W'(m_op));
        chk("m_alu_input1", alu_input1, m_a);
        chk("m_alu_input2", alu_input2, m_b);
        chk("m_alu_shift", W'(alu_shift), W'(m_sh));
        if (!m_busy) begin
          w = winner(req_valid, m_last);
          chk("m_req_ready", W'(req_ready), (w < 0) ? '0 : W'(1) << w);
          chk("m_rsp_valid_idle", W'(rsp_valid), '0);
          if (w >= 0) begin
            m_op   = req_opcode[w*OPW +: OPW];
            m_a    = req_a[w*W +: W];
            m_b    = req_b[w*W +: W];
            m_sh   = req_shift[w*SHW +: SHW];
            m_id   = w;
            m_last = w;
            m_busy = 1'b1;
            m_age  = 0;
            if (m_op >= 4'd8) begin
              m_exp = '0;
              m_err = 1'b1;
            end else begin
              m_exp = alu_f(m_op, m_a, m_b, m_sh);
              m_err = 1'b0;
            end
          end
        end else begin
          chk("m_req_ready_busy", W'(req_ready), '0);
          if (m_age == 0) begin
            chk("m_rsp_valid_exec", W'(rsp_valid), '0);
            m_age = 1;
          end else begin
            chk("m_rsp_valid", W'(rsp_valid), W'(1));
            chk("m_rsp_id", W'(rsp_id), W'(m_id));
            chk("m_rsp_result", rsp_result, m_exp.res);
            chk("m_rsp_carry", W'(rsp_carry), W'(m_exp.c));
            chk("m_rsp_zero", W'(rsp_zero), W'(m_exp.z));
            chk("m_rsp_overflow", W'(rsp_overflow), W'(m_exp.v));
            chk("m_rsp_err", W'(rsp_err), W'(m_err));
            if (rsp_ready) m_busy = 1'b0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed single transaction; results latched for the caller.
  // Entered at posedge+1 with the scheduler idle and rsp_ready high.
  // --------------------------------------------------------------------------
  logic [N-1:0]   s_rdy;
  logic [OPW-1:0] s_alu_op;
  logic           s_rv_exec;
  logic           s_rv;
  logic [IDW-1:0] s_id;
  logic [W-1:0]   s_res;
  logic           s_c, s_z, s_v, s_err;

  task automatic run_single(input int i, input logic [OPW-1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [SHW-1:0] sh);
    set_payload(i, op, a, b, sh);
    req_valid = N'(1) << i;
    @(negedge clk); s_rdy = req_ready;
    tick(); req_valid = '0;
    @(negedge clk); s_alu_op = alu_opcode; s_rv_exec = rsp_valid;
    @(negedge clk);
    s_rv = rsp_valid; s_id = rsp_id; s_res = rsp_result;
    s_c = rsp_carry; s_z = rsp_zero; s_v = rsp_overflow; s_err = rsp_err;
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  int           g_idx[$];
  int           g_cyc[$];
  logic [N-1:0] rdy;
  alu_o_t       pin;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0;
    req_shift = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_req_ready", W'(req_ready), '0);
    chk("rst_alu_opcode", W'(alu_opcode), '0);
    chk("rst_alu_input1", alu_input1, '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_rsp_flags", W'({rsp_carry, rsp_zero, rsp_overflow, rsp_err}), '0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Pin the bench ALU and arbitration model
    pin = alu_f(4'd0, 128'd5, 128'd7, 5'd0);
    chk("pin_add", pin.res, 128'd12);
    pin = alu_f(4'd1, 128'd3, 128'd5, 5'd0);
    chk("pin_sub_borrow", W'(pin.c), W'(1));
    pin = alu_f(4'd6, 128'h1, 128'd0, 5'd4);
    chk("pin_shl", pin.res, 128'h10);
    chk("pin_winner_wrap", W'(winner(4'b1111, 3)), W'(0));
    chk("pin_winner_skip", W'(winner(4'b1001, 1)), W'(3));

    // Single op: requester 2, pass-b
    run_single(2, 4'd4, rnd128(), 128'h1234, 5'd0);
    chk("single_ready", W'(s_rdy), W'(4'b0100));
    chk("single_alu_op", W'(s_alu_op), W'(4));
    chk("single_rv_exec", W'(s_rv_exec), '0);
    chk("single_rv", W'(s_rv), W'(1));
    chk("single_id", W'(s_id), W'(2));
    chk("single_res", s_res, 128'h1234);
    chk("single_zero", W'(s_z), '0);
    chk("single_err", W'(s_err), '0);

    // Illegal opcode
    run_single(0, 4'd12, 128'hdead_beef, 128'h55, 5'd3);
    chk("illegal_err", W'(s_err), W'(1));
    chk("illegal_res", s_res, '0);
    chk("illegal_flags", W'({s_c, s_z, s_v}), '0);

    // Zero flag from NOR of all-ones
    run_single(3, 4'd7, {W{1'b1}}, {W{1'b1}}, 5'd0);
    chk("nor_res", s_res, '0);
    chk("nor_zero", W'(s_z), W'(1));
    chk("nor_id", W'(s_id), W'(3));

    // Round-robin with all requesters continuously valid
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) rand_payload(i);
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); rdy = req_ready;
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin g_idx.push_back(i); g_cyc.push_back(c); end
      end
      tick();
      for (int i = 0; i < N; i++) if (rdy[i]) rand_payload(i);
    end
    chk("rr_count_ok", W'(g_idx.size() >= 5), W'(1));
    if (g_idx.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", W'(g_idx[k]), W'(k % N));
        if (k > 0) chk("rr_spacing", W'(g_cyc[k] - g_cyc[k-1]), W'(3));
      end
    end
    req_valid = '0;
    repeat (4) tick();

    // Backpressure: five RESP cycles with rsp_ready low
    rsp_ready = 1'b0;
    set_payload(1, 4'd0, 128'h1111_0000, 128'h0000_2222, 5'd0);
    req_valid = 4'b0010;
    @(negedge clk); chk("bp_grant", W'(req_ready), W'(4'b0010));
    tick();
    rand_payload(0); rand_payload(3);
    req_valid = 4'b1001;
    @(negedge clk); chk("bp_exec_ready", W'(req_ready), '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rv", W'(rsp_valid), W'(1));
      chk("bp_no_ready", W'(req_ready), '0);
      chk("bp_res_stable", rsp_result, 128'h1111_2222);
      chk("bp_id_stable", W'(rsp_id), W'(1));
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk); chk("bp_rv_hs", W'(rsp_valid), W'(1));
    tick();
    @(negedge clk); chk("bp_next_grant", W'(req_ready), W'(4'b1000));
    tick(); req_valid = '0;
    repeat (5) tick();

    // Reset in the middle of an operation
    set_payload(2, 4'd0, rnd128() | 128'h1, 128'h3, 5'd7);
    req_valid = 4'b0100;
    @(negedge clk);
    tick();
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rv", W'(rsp_valid), '0);
    chk("mid_rst_ready", W'(req_ready), '0);
    chk("mid_rst_alu_op", W'(alu_opcode), '0);
    chk("mid_rst_alu_in1", alu_input1, '0);
    chk("mid_rst_alu_in2", alu_input2, '0);
    chk("mid_rst_alu_sh", W'(alu_shift), '0);
    chk("mid_rst_rsp", rsp_result, '0);
    chk("mid_rst_id_flags", W'({rsp_id, rsp_carry, rsp_zero, rsp_overflow, rsp_err}), '0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk); chk("mid_rst_first_grant", W'(req_ready), W'(4'b0001));
    tick();

    // Randomized traffic; requesters hold payload until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); rdy = req_ready;
      tick();
      for (int i = 0; i < N; i++) begin
        if (rdy[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 40);
          rand_payload(i);
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one combinational 128-bit ALU among `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and registers the operands onto the ALU inputs. It captures the ALU result and flags one cycle later, then returns them with the requester ID over a response handshake. It sits between the issuing agents and the ALU instance and is the only driver of the ALU's inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 128: operand/result width.
- `OPW`, 4: opcode width.
- `SHW`, 5: shift-amount width.
- `IDW`, `$clog2(NUM_REQ)`: requester ID width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester operation valid.
- `req_ready` out NUM_REQ: per-requester accept, at most one bit high.
- `req_opcode` in NUM_REQ*OPW: packed opcodes; requester i uses slice i.
- `req_a`, `req_b` in NUM_REQ*WIDTH: packed operands.
- `req_shift` in NUM_REQ*SHW: packed shift amounts.
- `alu_opcode` out OPW, `alu_input1`/`alu_input2` out WIDTH, `alu_shift` out SHW: registered ALU drive.
- `alu_result` in WIDTH, `alu_carry`/`alu_zero`/`alu_overflow` in 1: ALU outputs.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out IDW, `rsp_result` out WIDTH.
- `rsp_carry`/`rsp_zero`/`rsp_overflow`/`rsp_err` out 1.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate over `req_valid` in round-robin order, starting at `last_grant+1` modulo NUM_REQ.
  - Drive `req_ready[g]=1` combinationally for the winner g only.
  - On that cycle, register slice g into `alu_*`, store `rsp_id<=g` and `last_grant<=g`, then go to EXEC.
  - With no valid request: stay in IDLE, all `req_ready` low.
- `req_ready` is 0 in EXEC and RESP. Requests arriving there wait; they are not queued.
- EXEC (exactly 1 cycle): capture `alu_result`/`alu_carry`/`alu_zero`/`alu_overflow` into the `rsp_*` registers, then go to RESP.
- RESP: `rsp_valid=1`, with all `rsp_*` fields stable. Go to IDLE on `rsp_valid & rsp_ready`; otherwise hold indefinitely.
- Illegal opcode (value >= 8):
  - Still occupies the EXEC slot.
  - Capture `rsp_result=0`, `rsp_carry=rsp_zero=rsp_overflow=0`, `rsp_err=1`.
  - Legal opcodes give `rsp_err=0`.
- `alu_*` registers hold their last operation between transactions. They change only on acceptance.
- Fairness: after requester g is granted, g has the lowest priority in the next arbitration. Every continuously valid requester is granted within NUM_REQ transactions.
- Requesters must hold valid and payload stable until ready. The scheduler does not check this.

## Timing
- Reset (async assert) state:
  - FSM = IDLE.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - `alu_*`, `rsp_*`, `rsp_valid` and all `req_ready` = 0.
- Reset asserted mid-transaction aborts the operation; no response is produced. Deassertion is synchronised externally.
- Accept in cycle T:
  - `alu_*` valid from T+1.
  - `rsp_valid` rises at T+2. Latency is 2 cycles.
- `rsp_ready` high at T+2 completes the handshake. The FSM is in IDLE at T+3, and the next accept can occur at T+3.
- Maximum throughput is 1 op per 3 cycles. Each cycle of `rsp_ready` low adds one cycle.
- A `rsp_ready` high outside RESP is ignored.

## Test plan
- Single op: after reset, requester 2 issues opcode 4 with b=128'h1234. Required: `req_ready[2]` in the same cycle; `alu_opcode=4` at T+1; `rsp_valid` at T+2 with `rsp_id=2`, `rsp_result=128'h1234`, `rsp_zero=0`, `rsp_err=0`.
- Round-robin: all four requesters continuously valid. Required grant order is 0,1,2,3,0, with one grant every 3 cycles when `rsp_ready=1`.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP. Required: `rsp_*` stable, no `req_ready`; the next grant comes on the cycle after the handshake.
- Illegal opcode: opcode 4'd12 with nonzero operands. Required response: `rsp_err=1`, `rsp_result=0`, all flags 0.
- Zero flag: opcode 7 (NOR) with a=b=all-ones. Required: `rsp_result=0`, `rsp_zero=1`.
- Reset mid-op: assert `rsp_n` low during EXEC. Required: immediately `rsp_valid=0` and all outputs 0; after release the first grant goes to requester 0.
